// File: rtl/program_counter_if.sv
// program_counter_if: control/decode to PC bus (jump, branch, pc_in in; pc out)
// master: control side drives jump, branch, pc_in and reads pc
// slave:  program counter samples jump, branch, pc_in and drives pc
interface program_counter_if;
    logic        jump;
    logic        branch;
    logic [31:0] pc_in;
    logic [31:0] pc;
    modport master (output jump, branch, pc_in, input pc);
    modport slave  (input jump, branch, pc_in, output pc);
endinterface

// File: rtl/program_counter.sv
// program_counter: 32-bit word-address PC with jump (absolute) and branch (pc+1+signed offset)
// clk   : rising-edge clock
// reset : asynchronous active-high, clears pc to 0
// bus   : jump/branch/pc_in in, registered pc out
module program_counter (
    input  logic                  clk,
    input  logic                  reset,
    program_counter_if.slave      bus
);
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] pc_inc;
    // Branch offsets are relative to the next sequential instruction; modulo 2^32 wrap is intended.
    always_comb begin
        pc_inc  = pc_q + 32'd1;
        pc_next = bus.jump ? bus.pc_in : bus.branch ? pc_inc + bus.pc_in : pc_inc;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) pc_q <= '0;
        else       pc_q <= pc_next;
    assign bus.pc = pc_q;
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: self-checking bench for program_counter
`timescale 1ns/1ps
module tb_program_counter;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   failed = 0;
    logic [31:0] mdl;

    program_counter_if bus();
    program_counter dut (.clk(clk), .reset(reset), .bus(bus));

    always #2 clk = ~clk;

    typedef struct {
        logic        j;
        logic        b;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;

    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic j, input logic b,
                                             input logic [31:0] d);
        longint t;
        if (j) return d;
        t = longint'(cur) + 64'sd1 + (b ? longint'($signed(d)) : 64'sd0);
        return t[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: pc=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic j, input logic b, input logic [31:0] d, input string name);
        bus.jump = j; bus.branch = b; bus.pc_in = d;
        mdl = ref_next(mdl, j, b, d);
        @(posedge clk); #1;
        check(name, bus.pc, mdl);
    endtask

    vec_t vecs[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs = '{
            '{1'b1, 1'b0, 32'd20,         32'd20,         "jump20"},
            '{1'b0, 1'b1, 32'hFFFF_FFFB,  32'd16,         "branch_neg5"},
            '{1'b1, 1'b1, 32'd100,        32'd100,        "jump_wins"},
            '{1'b0, 1'b0, 32'hDEAD_BEEF,  32'd101,        "pc_in_ignored"},
            '{1'b1, 1'b0, 32'hFFFF_FFFE,  32'hFFFF_FFFE,  "jump_top"},
            '{1'b0, 1'b0, 32'd0,          32'hFFFF_FFFF,  "wrap_ff"},
            '{1'b0, 1'b0, 32'd0,          32'd0,          "wrap_zero"},
            '{1'b0, 1'b1, 32'hFFFF_FFFA,  32'hFFFF_FFFB,  "branch_wrap_back"},
            '{1'b1, 1'b0, 32'd5,          32'd5,          "jump5"},
            '{1'b0, 1'b1, 32'hFFFF_FFFA,  32'd0,          "branch_neg6_to0"},
            '{1'b0, 1'b1, 32'd0,          32'd1,          "branch_zero_off"},
            '{1'b1, 1'b0, 32'd50,         32'd50,         "jump_held1"},
            '{1'b1, 1'b0, 32'd50,         32'd50,         "jump_held2"},
            '{1'b1, 1'b0, 32'd50,         32'd50,         "jump_held3"}
        };
        reset = 1'b1; bus.jump = 1'b0; bus.branch = 1'b0; bus.pc_in = 32'd0;
        #1;
        check("async_reset_t1", bus.pc, 32'd0);
        #3;
        check("reset_held_edge", bus.pc, 32'd0);
        #1 reset = 1'b0;
        mdl = 32'd0;
        step(1'b0, 1'b0, 32'd0, "first_inc");
        check("first_inc_is_1", bus.pc, 32'd1);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 32'd0, "count");
        check("count_25", bus.pc, 32'd25);
        step(1'b1, 1'b0, 32'd12, "jump12");
        check("jump12_abs", bus.pc, 32'd12);
        for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 32'd0, "count2");
        check("count_37", bus.pc, 32'd37);
        step(1'b0, 1'b1, 32'd3, "branch3");
        check("branch3_abs", bus.pc, 32'd41);
        step(1'b0, 1'b0, 32'd0, "after_branch");
        check("after_branch_abs", bus.pc, 32'd42);

        foreach (vecs[i]) begin
            bus.jump = vecs[i].j; bus.branch = vecs[i].b; bus.pc_in = vecs[i].d;
            @(posedge clk); #1;
            check(vecs[i].name, bus.pc, vecs[i].exp);
            mdl = vecs[i].exp;
        end

        for (int i = 0; i < 300; i++)
            step($urandom_range(7) == 0, $urandom_range(3) == 0, $urandom, "random");

        step(1'b1, 1'b0, 32'd28, "pre_reset_jump");
        step(1'b0, 1'b0, 32'd0, "pre_reset_inc");
        step(1'b0, 1'b0, 32'd0, "pre_reset_30");
        bus.jump = 1'b1; bus.pc_in = 32'd77;
        #1 reset = 1'b1;
        #0.5;
        check("async_reset_mid", bus.pc, 32'd0);
        @(posedge clk); #1;
        check("reset_hold_edge1", bus.pc, 32'd0);
        @(posedge clk); #1;
        check("reset_hold_edge2", bus.pc, 32'd0);
        bus.jump = 1'b0;
        #1 reset = 1'b0;
        mdl = 32'd0;
        step(1'b0, 1'b0, 32'd0, "resume1");
        check("resume_is_1", bus.pc, 32'd1);
        step(1'b0, 1'b0, 32'd0, "resume2");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
